// File: rtl/sci_fifo_wr_arb.sv
// rtl/sci_fifo_wr_arb.sv - two-source framed write arbiter for the science-buffer FIFO
// Frames: EB 25 <id> 76, payload, XOR checksum; round-robin between sources.
module sci_fifo_wr_arb #(
    parameter int PTRWIDTH = 12,
    parameter int MARGIN   = 300,
    parameter int MAXLEN   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PTRWIDTH:0]   uw,
    input  logic                req0,
    input  logic                wen0,
    input  logic [7:0]          din0,
    input  logic                req1,
    input  logic                wen1,
    input  logic [7:0]          din1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                valid,
    output logic [7:0]          dout,
    output logic                trunc
);

    localparam int              DEPTH = 2 ** PTRWIDTH;
    localparam logic [PTRWIDTH:0] LIMIT = (PTRWIDTH + 1)'(DEPTH - MARGIN);
    localparam logic [15:0]     MAXL  = 16'(MAXLEN);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_HEAD = 5'b00010;
    localparam logic [4:0] S_DATA = 5'b00100;
    localparam logic [4:0] S_SUM  = 5'b01000;
    localparam logic [4:0] S_GAP  = 5'b10000;

    logic [4:0]  r_state;
    logic        r_id;
    logic        r_last;
    logic [1:0]  r_hcnt;
    logic [15:0] r_len;
    logic [7:0]  r_csum;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_valid;
    logic [7:0]  r_dout;
    logic        r_trunc;

    logic        w_req;
    logic        w_wen;
    logic [7:0]  w_din;
    logic        w_pick;
    logic        w_start;
    logic        w_hit;
    logic        w_exit;

    assign w_req   = r_id ? req1 : req0;
    assign w_wen   = r_id ? wen1 : wen0;
    assign w_din   = r_id ? din1 : din0;
    // With both requesting, the source not served last wins.
    assign w_pick  = (req0 && req1) ? ~r_last : req1;
    assign w_start = (req0 || req1) && (uw < LIMIT);
    assign w_hit   = w_wen && ((r_len + 16'd1) == MAXL);
    assign w_exit  = !w_req || w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_hcnt  <= 2'd0;
            r_len   <= 16'd0;
            r_csum  <= 8'h00;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= 8'h00;
            r_trunc <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_trunc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_id    <= w_pick;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                        r_hcnt  <= 2'd0;
                        r_len   <= 16'd0;
                        r_csum  <= 8'h00;
                        r_state <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    r_valid <= 1'b1;
                    case (r_hcnt)
                        2'd0:    r_dout <= 8'hEB;
                        2'd1:    r_dout <= 8'h25;
                        2'd2:    r_dout <= {7'b0, r_id};
                        default: r_dout <= 8'h76;
                    endcase
                    r_hcnt <= r_hcnt + 2'd1;
                    if (r_hcnt == 2'd3) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_valid <= w_wen;
                    if (w_wen) begin
                        r_dout <= w_din;
                        r_len  <= r_len + 16'd1;
                        r_csum <= r_csum ^ w_din;
                    end
                    if (w_exit) begin
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_trunc <= w_hit && w_req;
                        r_state <= S_SUM;
                    end
                end
                S_SUM: begin
                    r_valid <= 1'b1;
                    r_dout  <= r_csum;
                    r_last  <= r_id;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign valid = r_valid;
    assign dout  = r_dout;
    assign trunc = r_trunc;

endmodule

// File: tb/tb_sci_fifo_wr_arb.sv
// tb/tb_sci_fifo_wr_arb.sv - self-checking bench for sci_fifo_wr_arb
// Frames captured from the FIFO port are compared with frames built from the byte rules.
module tb_sci_fifo_wr_arb;

    localparam int MAXLEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] uw = '0;
    logic        req0 = 1'b0, wen0 = 1'b0, req1 = 1'b0, wen1 = 1'b0;
    logic [7:0]  din0 = '0, din1 = '0;
    logic        gnt0, gnt1, valid, trunc;
    logic [7:0]  dout;

    sci_fifo_wr_arb #(.PTRWIDTH(12), .MARGIN(300), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst_n(rst_n), .uw(uw),
        .req0(req0), .wen0(wen0), .din0(din0),
        .req1(req1), .wen1(wen1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .valid(valid), .dout(dout), .trunc(trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            src;
        logic [2:0]      n;
        logic [3:0][7:0] b;
        logic [3:0]      len;
        logic [8:0][7:0] exp;
    } tvec_t;

    tvec_t      tv [5];
    int         tests = 0;
    int         fails = 0;
    int         trunc_cnt = 0;
    int         both_cnt = 0;
    int         model_last;
    logic [7:0] wq[$];
    logic [7:0] eq[$];
    logic [7:0] pq[$];
    logic [7:0] pay [16];

    // Monitor samples 2 time units after the rising edge.
    always @(posedge clk) begin
        #2;
        if (rst_n && valid) wq.push_back(dout);
        if (trunc) trunc_cnt++;
        if (gnt0 && gnt1) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic g(input int src);
        return (src != 0) ? gnt1 : gnt0;
    endfunction

    task automatic drive(input int src, input logic r, input logic w, input logic [7:0] d);
        if (src == 0) begin req0 = r; wen0 = w; din0 = d; end
        else          begin req1 = r; wen1 = w; din1 = d; end
    endtask

    task automatic noise(input int src);
        if (src == 0) begin wen1 = 1'($urandom); din1 = 8'($urandom); end
        else          begin wen0 = 1'($urandom); din0 = 8'($urandom); end
    endtask

    task automatic quiet();
        wen0 = 1'b0; wen1 = 1'b0;
    endtask

    task automatic wait_gnt(input int src, input string name);
        int got = 2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = gnt1 ? 1 : 0;
                break;
            end
        end
        check(name, got, src);
    endtask

    // Source behaviour: wait for grant, sit out the 4 header cycles, then
    // offer n bytes from pay[], dropping req together with the last byte.
    task automatic serve(input int src, input int n, input bit gaps, input string name);
        int i = 0;
        wait_gnt(src, name);
        repeat (4) begin noise(src); @(negedge clk); end
        if (n == 0) begin
            drive(src, 1'b0, 1'b0, 8'h00);
            noise(src);
            @(negedge clk);
        end else begin
            while (i < n && g(src)) begin
                noise(src);
                if (gaps && $urandom_range(0, 2) == 0) begin
                    drive(src, 1'b1, 1'b0, 8'h00);
                end else begin
                    drive(src, (i != n - 1), 1'b1, pay[i]);
                    i++;
                end
                @(negedge clk);
            end
        end
        drive(src, 1'b0, 1'b0, 8'h00);
        quiet();
    endtask

    task automatic build(input int id, input int n);
        logic [7:0] x = 8'h00;
        int m = (n < MAXLEN) ? n : MAXLEN;
        eq = {8'hEB, 8'h25, 8'(id), 8'h76};
        for (int k = 0; k < m; k++) begin
            eq.push_back(pay[k]);
            x ^= pay[k];
        end
        eq.push_back(x);
    endtask

    task automatic check_frame(input string name);
        int bad = -1;
        for (int k = 0; k < 20 && wq.size() < eq.size(); k++) @(negedge clk);
        tests++;
        if (wq.size() < eq.size()) begin
            fails++;
            $display("FAIL %s: got %0d bytes required %0d bytes", name, wq.size(), eq.size());
            wq.delete();
        end else begin
            for (int k = 0; k < eq.size(); k++)
                if (bad < 0 && wq[k] !== eq[k]) bad = k;
            if (bad >= 0) begin
                fails++;
                $display("FAIL %s: byte %0d got %02h required %02h", name, bad, wq[bad], eq[bad]);
            end
            for (int k = 0; k < eq.size(); k++) void'(wq.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0; uw = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wq.delete();
        model_last = 1;
    endtask

    initial begin
        int tc;
        tv[0] = '{src: 1'b0, n: 3'd3, b: {8'h00, 8'h44, 8'h22, 8'h11}, len: 4'd8,
                  exp: {8'h00, 8'h77, 8'h44, 8'h22, 8'h11, 8'h76, 8'h00, 8'h25, 8'hEB}};
        tv[1] = '{src: 1'b1, n: 3'd2, b: {8'h00, 8'h00, 8'h5A, 8'hA5}, len: 4'd7,
                  exp: {8'h00, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h76, 8'h01, 8'h25, 8'hEB}};
        tv[2] = '{src: 1'b0, n: 3'd0, b: 32'h0, len: 4'd5,
                  exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h76, 8'h00, 8'h25, 8'hEB}};
        tv[3] = '{src: 1'b1, n: 3'd1, b: {8'h00, 8'h00, 8'h00, 8'h80}, len: 4'd6,
                  exp: {8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h76, 8'h01, 8'h25, 8'hEB}};
        tv[4] = '{src: 1'b0, n: 3'd4, b: {8'h08, 8'h04, 8'h02, 8'h01}, len: 4'd9,
                  exp: {8'h0F, 8'h08, 8'h04, 8'h02, 8'h01, 8'h76, 8'h00, 8'h25, 8'hEB}};

        // Reset state, during and just after reset.
        repeat (2) @(negedge clk);
        check("reset_outputs", {gnt0, gnt1, valid, trunc, dout}, 12'h000);
        do_reset();
        check("idle_outputs", {gnt0, gnt1, valid, trunc, dout}, 12'h000);

        // Table-driven single-source frames.
        for (int i = 0; i < 5; i++) begin
            tc = trunc_cnt;
            for (int k = 0; k < 4; k++) pay[k] = tv[i].b[k];
            drive(int'(tv[i].src), 1'b1, 1'b0, 8'h00);
            serve(int'(tv[i].src), int'(tv[i].n), 1'b0, $sformatf("tv%0d_gnt", i));
            eq.delete();
            for (int k = 0; k < int'(tv[i].len); k++) eq.push_back(tv[i].exp[k]);
            check_frame($sformatf("tv%0d_frame", i));
            check($sformatf("tv%0d_trunc", i), trunc_cnt - tc, 0);
            repeat (2) @(negedge clk);
        end

        // Fill-level gate at the exact threshold, then req dropped during HEAD.
        uw = 13'd3796;
        req0 = 1'b1;
        repeat (5) @(negedge clk);
        check("uw_block_gnt", {gnt0, gnt1}, 2'b00);
        check("uw_block_writes", wq.size(), 0);
        uw = 13'd3795;
        @(negedge clk);
        check("uw_start_gnt", {gnt0, gnt1}, 2'b10);
        uw = 13'd4095;
        req0 = 1'b0;
        eq = {8'hEB, 8'h25, 8'h00, 8'h76, 8'h00};
        check_frame("head_drop_frame");
        repeat (3) @(negedge clk);
        check("head_drop_idle", {gnt0, gnt1, valid}, 3'b000);
        uw = '0;

        // Round robin: simultaneous requests, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            req0 = 1'b1; req1 = 1'b1;
            serve(0, 0, 1'b0, $sformatf("rr%0d_first", r));
            eq = {8'hEB, 8'h25, 8'h00, 8'h76, 8'h00};
            check_frame($sformatf("rr%0d_frame0", r));
            serve(1, 0, 1'b0, $sformatf("rr%0d_second", r));
            eq = {8'hEB, 8'h25, 8'h01, 8'h76, 8'h00};
            check_frame($sformatf("rr%0d_frame1", r));
            repeat (2) @(negedge clk);
        end

        // MAXLEN truncation with continuous wen1, two back-to-back frames.
        tc = trunc_cnt;
        pq.delete();
        begin
            int k = 0;
            drive(1, 1'b1, 1'b1, 8'h40);
            for (int c = 0; c < 80 && wq.size() < 18; c++) begin
                @(negedge clk);
                din1 = din1 + 8'd1;
                if (gnt1) begin
                    if (k >= 4) pq.push_back(din1);
                    k++;
                end else begin
                    k = 0;
                end
            end
            drive(1, 1'b0, 1'b0, 8'h00);
        end
        check("trunc_payload_bytes", pq.size(), 8);
        check("trunc_pulses", trunc_cnt - tc, 2);
        if (pq.size() >= 8) begin
            for (int f = 0; f < 2; f++) begin
                for (int k = 0; k < 4; k++) pay[k] = pq[4 * f + k];
                build(1, 8);
                check_frame($sformatf("trunc_frame%0d", f));
            end
        end
        repeat (4) @(negedge clk);
        check("trunc_no_third", {gnt1, valid}, 2'b00);

        // Reset asserted mid-DATA, then a clean frame.
        wq.delete();
        req0 = 1'b1;
        wait_gnt(0, "middata_gnt");
        repeat (4) @(negedge clk);
        wen0 = 1'b1; din0 = 8'h33;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("middata_reset", {gnt0, gnt1, valid, trunc}, 4'b0000);
        req0 = 1'b0; wen0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wq.delete();
        pay[0] = 8'h5C;
        req0 = 1'b1;
        serve(0, 1, 1'b0, "post_reset_gnt");
        build(0, 1);
        check_frame("post_reset_frame");

        // Randomized traffic against the frame-level model.
        do_reset();
        for (int it = 0; it < 30; it++) begin
            int mode = $urandom_range(0, 2);
            int first = (mode == 2) ? (1 - model_last) : mode;
            int cnt = (mode == 2) ? 2 : 1;
            if (mode != 1) req0 = 1'b1;
            if (mode != 0) req1 = 1'b1;
            for (int s = 0; s < cnt; s++) begin
                int src = (s == 0) ? first : 1 - first;
                int n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
                tc = trunc_cnt;
                serve(src, n, 1'b1, $sformatf("rnd%0d_gnt%0d", it, s));
                build(src, n);
                check_frame($sformatf("rnd%0d_frame%0d", it, s));
                check($sformatf("rnd%0d_trunc%0d", it, s), trunc_cnt - tc, (n > MAXLEN) ? 1 : 0);
                model_last = src;
            end
            repeat ($urandom_range(2, 4)) @(negedge clk);
        end

        check("gnt_exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
